matmul_apb_slave: RTL and testbench

- APB responder for the matrix-multiply accelerator; the bus-side counterpart of the stimulus initiator that replays bus instruction files.
- Decodes APB transfers into a control register, operand A/B row banks, a flags register and a result read window. Launches the compute core with a start pulse and tracks busy/done.
- Sits between the top-level APB interface and the matmul compute core.

---
 rtl/matmul_apb_slave.sv | 196 +++++++++++++++++++
 tb/tb_matmul_apb_slave.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_apb_slave.sv
// APB register front-end for the matmul accelerator: control, operand banks, flags and result window.
// Build option: define PSLVERR_EN to report bad accesses on pslverr_o; otherwise they are silently ignored.
module matmul_apb_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int MAX_DIM     = 4,
  parameter int SP_NTARGETS = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic                         pwrite_i,
  input  logic [BUS_WIDTH/8-1:0]       pstrb_i,
  input  logic [ADDR_WIDTH-1:0]        paddr_i,
  input  logic [BUS_WIDTH-1:0]         pwdata_i,
  output logic [BUS_WIDTH-1:0]         prdata_o,
  output logic                         pready_o,
  output logic                         pslverr_o,
  output logic                         start_o,
  output logic [1:0]                   dim_n_o,
  output logic [1:0]                   dim_k_o,
  output logic [1:0]                   dim_m_o,
  output logic [1:0]                   sp_slot_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0] a_rows_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0] b_cols_o,
  input  logic                         done_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]   flags_i,
  output logic [ADDR_WIDTH-1:0]        res_addr_o,
  input  logic [BUS_WIDTH-1:0]         res_data_i
);

  localparam int STRB_W    = BUS_WIDTH / 8;
  localparam int IDX_W     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int FLAG_W    = MAX_DIM * MAX_DIM;
  localparam int RES_WORDS = SP_NTARGETS * MAX_DIM * MAX_DIM;
  localparam int BUSY_BIT  = 15;

  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR  = '0;
  localparam logic [ADDR_WIDTH-1:0] OPA_LO     = ADDR_WIDTH'(32'h20);
  localparam logic [ADDR_WIDTH-1:0] OPA_HI     = ADDR_WIDTH'(32'h20 + 4 * MAX_DIM);
  localparam logic [ADDR_WIDTH-1:0] OPB_LO     = ADDR_WIDTH'(32'h40);
  localparam logic [ADDR_WIDTH-1:0] OPB_HI     = ADDR_WIDTH'(32'h40 + 4 * MAX_DIM);
  localparam logic [ADDR_WIDTH-1:0] FLAGS_ADDR = ADDR_WIDTH'(32'h60);
  localparam logic [ADDR_WIDTH-1:0] RES_LO     = ADDR_WIDTH'(32'h80);
  localparam logic [ADDR_WIDTH-1:0] RES_HI     = ADDR_WIDTH'(32'h80 + 4 * RES_WORDS);
  localparam logic [BUS_WIDTH-1:0]  CTRL_MASK  = BUS_WIDTH'(32'h0000_03FC);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RWAIT  = 2'd2;

  if (MAX_DIM != BUS_WIDTH / DATA_WIDTH) begin : g_bad_cfg
    $error("MAX_DIM must equal BUS_WIDTH/DATA_WIDTH");
  end

  logic [1:0]            state_q;
  logic [BUS_WIDTH-1:0]  ctrl_q;
  logic [BUS_WIDTH-1:0]  opa_q [MAX_DIM];
  logic [BUS_WIDTH-1:0]  opb_q [MAX_DIM];
  logic [FLAG_W-1:0]     flags_q;
  logic                  busy_q;
  logic [BUS_WIDTH-1:0]  prdata_q;
  logic [BUS_WIDTH-1:0]  rd_word;

  // Address decode, evaluated on the live APB address.
  logic aligned, sel_ctrl, sel_opa, sel_opb, sel_flags, sel_res, sel_cfg, unmapped;
  logic [IDX_W-1:0]      opa_idx, opb_idx;
  logic [ADDR_WIDTH-1:0] res_word;

  assign aligned   = (paddr_i[1:0] == 2'b00);
  assign sel_ctrl  = (paddr_i == CTRL_ADDR);
  assign sel_opa   = aligned && (paddr_i >= OPA_LO) && (paddr_i < OPA_HI);
  assign sel_opb   = aligned && (paddr_i >= OPB_LO) && (paddr_i < OPB_HI);
  assign sel_flags = (paddr_i == FLAGS_ADDR);
  assign sel_res   = aligned && (paddr_i >= RES_LO) && (paddr_i < RES_HI);
  assign sel_cfg   = sel_ctrl || sel_opa || sel_opb;
  assign unmapped  = !(sel_cfg || sel_flags || sel_res);
  assign opa_idx   = IDX_W'((paddr_i - OPA_LO) >> 2);
  assign opb_idx   = IDX_W'((paddr_i - OPB_LO) >> 2);
  assign res_word  = (paddr_i - RES_LO) >> 2;

  logic xfer, res_rd, fast_done, cfg_blocked, wr_ok, cfg_we, start_req;

  assign xfer        = (state_q == ST_ACCESS) && psel_i && penable_i;
  assign res_rd      = xfer && !pwrite_i && sel_res;
  assign fast_done   = xfer && !res_rd;
  // A done arriving in the same cycle frees the core, so that write is accepted.
  assign cfg_blocked = busy_q && !done_i;
  assign wr_ok       = fast_done && pwrite_i;
  assign cfg_we      = wr_ok && sel_cfg && !cfg_blocked;
  assign start_req   = cfg_we && sel_ctrl && pstrb_i[0] && pwdata_i[0];

  assign pready_o = fast_done || ((state_q == ST_RWAIT) && psel_i && penable_i);

`ifdef PSLVERR_EN
  logic bus_err;
  assign bus_err   = xfer && (unmapped || (pwrite_i && (sel_res || (sel_cfg && cfg_blocked))));
  assign pslverr_o = pready_o && bus_err;
`else
  assign pslverr_o = 1'b0;
`endif

  function automatic logic [BUS_WIDTH-1:0] merge_bytes(input logic [BUS_WIDTH-1:0] cur,
                                                       input logic [BUS_WIDTH-1:0] wdata,
                                                       input logic [STRB_W-1:0]    strb);
    logic [BUS_WIDTH-1:0] res;
    res = cur;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (psel_i && !penable_i) state_q <= ST_ACCESS;
        ST_ACCESS: state_q <= res_rd ? ST_RWAIT : ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the operand banks are a handful of flops feeding the core directly, so they are reset
  // like any other register rather than treated as an uninitialised memory.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q  <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      start_o <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++) begin
        opa_q[i] <= '0;
        opb_q[i] <= '0;
      end
    end else begin
      start_o <= start_req;
      if (cfg_we && sel_ctrl) ctrl_q <= merge_bytes(ctrl_q, pwdata_i, pstrb_i) & CTRL_MASK;
      if (cfg_we && sel_opa)  opa_q[opa_idx] <= merge_bytes(opa_q[opa_idx], pwdata_i, pstrb_i);
      if (cfg_we && sel_opb)  opb_q[opb_idx] <= merge_bytes(opb_q[opb_idx], pwdata_i, pstrb_i);
      // Fresh flags from the core take priority over a software clear.
      if (done_i)                    flags_q <= flags_i;
      else if (wr_ok && sel_flags)   flags_q <= '0;
      if (start_req)   busy_q <= 1'b1;
      else if (done_i) busy_q <= 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_word = '0;
    if (sel_ctrl)       rd_word = ctrl_q | (BUS_WIDTH'(busy_q) << BUSY_BIT);
    else if (sel_opa)   rd_word = opa_q[opa_idx];
    else if (sel_opb)   rd_word = opb_q[opb_idx];
    else if (sel_flags) rd_word = BUS_WIDTH'(flags_q);
  end

  // Read data is presented combinationally in the completing cycle and held afterwards.
  always_comb begin
    prdata_o = prdata_q;
    if (state_q == ST_RWAIT)
      prdata_o = res_data_i;
    else if ((state_q == ST_ACCESS) && !pwrite_i && !sel_res)
      prdata_o = rd_word;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prdata_q   <= '0;
      res_addr_o <= '0;
    end else begin
      if (fast_done && !pwrite_i)
        prdata_q <= rd_word;
      else if ((state_q == ST_RWAIT) && psel_i && penable_i)
        prdata_q <= res_data_i;
      if ((state_q == ST_IDLE) && psel_i && !penable_i && !pwrite_i && sel_res)
        res_addr_o <= res_word;
    end
  end

  assign dim_n_o   = ctrl_q[3:2];
  assign dim_k_o   = ctrl_q[5:4];
  assign dim_m_o   = ctrl_q[7:6];
  assign sp_slot_o = ctrl_q[9:8];

  for (genvar i = 0; i < MAX_DIM; i++) begin : g_pack
    assign a_rows_o[i*BUS_WIDTH +: BUS_WIDTH] = opa_q[i];
    assign b_cols_o[i*BUS_WIDTH +: BUS_WIDTH] = opb_q[i];
  end

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Self-checking bench for matmul_apb_slave: directed checks plus randomized APB traffic vs a transaction model.
module tb_matmul_apb_slave;

`ifdef PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int R_CTRL = 0, R_OPA = 1, R_OPB = 2, R_FLAGS = 3, R_RES = 4, R_UNM = 5;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         psel_i, penable_i, pwrite_i;
  logic [3:0]   pstrb_i;
  logic [15:0]  paddr_i;
  logic [31:0]  pwdata_i, prdata_o;
  logic         pready_o, pslverr_o, start_o;
  logic [1:0]   dim_n_o, dim_k_o, dim_m_o, sp_slot_o;
  logic [127:0] a_rows_o, b_cols_o;
  logic         done_i;
  logic [15:0]  flags_i;
  logic [15:0]  res_addr_o;
  logic [31:0]  res_data_i;

  always #5 clk_i = ~clk_i;

  matmul_apb_slave dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .pstrb_i(pstrb_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o), .start_o(start_o),
    .dim_n_o(dim_n_o), .dim_k_o(dim_k_o), .dim_m_o(dim_m_o), .sp_slot_o(sp_slot_o),
    .a_rows_o(a_rows_o), .b_cols_o(b_cols_o), .done_i(done_i), .flags_i(flags_i),
    .res_addr_o(res_addr_o), .res_data_i(res_data_i)
  );

  // Result memory of the core: answers one cycle after the address.
  logic [31:0] res_mem [64];
  always @(posedge clk_i) res_data_i <= res_mem[res_addr_o[5:0]];

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Model state: register contents as seen after the most recent clock edge.
  logic [31:0] m_opa [4];
  logic [31:0] m_opb [4];
  logic [1:0]  m_n, m_k, m_m, m_slot;
  logic [15:0] m_flags;
  bit          m_busy, m_start;
  logic [31:0] m_hold;

  // Expectations for the current cycle.
  bit          cmp_en = 1'b0;
  bit          exp_pready, exp_err, exp_rdchk, exp_reschk;
  logic [31:0] exp_rd;
  logic [15:0] exp_res;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_opa[i] = '0;
      m_opb[i] = '0;
    end
    {m_n, m_k, m_m, m_slot} = '0;
    m_flags = '0; m_busy = 0; m_start = 0; m_hold = '0;
  endtask

  function automatic int region(input logic [15:0] a);
    if (a[1:0] != 2'b00) return R_UNM;
    if (a == 16'h0) return R_CTRL;
    if (a >= 16'h20 && a < 16'h30) return R_OPA;
    if (a >= 16'h40 && a < 16'h50) return R_OPB;
    if (a == 16'h60) return R_FLAGS;
    if (a >= 16'h80 && a < 16'h180) return R_RES;
    return R_UNM;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] v = cur;
    for (int b = 0; b < 4; b++) if (st[b]) v[8*b +: 8] = wd[8*b +: 8];
    return v;
  endfunction

  function automatic logic [31:0] rd_model(input logic [15:0] a);
    case (region(a))
      R_CTRL:  return 32'(m_slot) * 256 + 32'(m_m) * 64 + 32'(m_k) * 16 + 32'(m_n) * 4
                      + (m_busy ? 32'h8000 : 32'h0);
      R_OPA:   return m_opa[(a - 16'h20) / 4];
      R_OPB:   return m_opb[(a - 16'h40) / 4];
      R_FLAGS: return {16'h0, m_flags};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit err_model(input bit wr, input logic [15:0] a, input bit dn);
    int r = region(a);
    bit e = (r == R_UNM) || (wr && ((r == R_RES) || (r <= R_OPB && m_busy && !dn)));
    return ERR_EN && e;
  endfunction

  task automatic model_update(input bit commit, input logic [15:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input bit dn, input logic [15:0] fl);
    int r = region(a);
    bit blocked = m_busy && !dn;
    bit start_now = 0;
    if (commit) begin
      if (r == R_CTRL && !blocked) begin
        if (st[0]) begin
          m_n = wd[3:2]; m_k = wd[5:4]; m_m = wd[7:6]; start_now = wd[0];
        end
        if (st[1]) m_slot = wd[9:8];
      end
      if (r == R_OPA && !blocked) m_opa[(a - 16'h20) / 4] = merge(m_opa[(a - 16'h20) / 4], wd, st);
      if (r == R_OPB && !blocked) m_opb[(a - 16'h40) / 4] = merge(m_opb[(a - 16'h40) / 4], wd, st);
      if (r == R_FLAGS) m_flags = '0;
    end
    if (dn) begin
      m_flags = fl;
      m_busy  = 0;
    end
    if (start_now) m_busy = 1;
    m_start = start_now;
  endtask

  // One clock cycle: drive inputs after the edge, publish expectations, advance the model after sampling.
  task automatic step(input bit s_sel, input bit s_en, input bit s_wr, input logic [15:0] s_addr,
                      input logic [31:0] s_wd, input logic [3:0] s_st, input bit s_dn,
                      input logic [15:0] s_fl, input bit e_rdy, input bit e_err, input bit e_rdchk,
                      input logic [31:0] e_rd, input bit e_reschk, input logic [15:0] e_res,
                      input bit commit);
    @(posedge clk_i); #1;
    psel_i = s_sel; penable_i = s_en; pwrite_i = s_wr; paddr_i = s_addr;
    pwdata_i = s_wd; pstrb_i = s_st; done_i = s_dn; flags_i = s_fl;
    exp_pready = e_rdy; exp_err = e_err; exp_rdchk = e_rdchk; exp_rd = e_rd;
    exp_reschk = e_reschk; exp_res = e_res;
    @(negedge clk_i); #1;
    model_update(commit, s_addr, s_wd, s_st, s_dn, s_fl);
    if (e_rdchk) m_hold = e_rd;
  endtask

  task automatic idle(input bit dn, input logic [15:0] fl);
    step(0, 0, 0, 16'h0, 32'h0, 4'h0, dn, fl, 0, 0, 0, 32'h0, 0, 16'h0, 0);
  endtask

  task automatic apb(input bit wr, input logic [15:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input bit dn, input logic [15:0] fl);
    logic [15:0] idx;
    step(1, 0, wr, a, wd, st, 0, 16'h0, 0, 0, 0, 32'h0, 0, 16'h0, 0);
    if (!wr && region(a) == R_RES) begin
      idx = (a - 16'h80) >> 2;
      step(1, 1, 0, a, wd, st, 0, 16'h0, 0, 0, 0, 32'h0, 1, idx, 0);
      step(1, 1, 0, a, wd, st, dn, fl, 1, 0, 1, res_mem[idx[5:0]], 0, 16'h0, 0);
    end else begin
      step(1, 1, wr, a, wd, st, dn, fl, 1, err_model(wr, a, dn), !wr, rd_model(a), 0, 16'h0, wr);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("a_rows", a_rows_o, {m_opa[3], m_opa[2], m_opa[1], m_opa[0]});
      check("b_cols", b_cols_o, {m_opb[3], m_opb[2], m_opb[1], m_opb[0]});
      check("dims", {dim_n_o, dim_k_o, dim_m_o, sp_slot_o}, {m_n, m_k, m_m, m_slot});
      check("start", start_o, m_start);
      check("pready", pready_o, exp_pready);
      check("pslverr", pslverr_o, exp_err);
      if (exp_rdchk) check("prdata", prdata_o, exp_rd);
      else           check("prdata_hold", prdata_o, m_hold);
      if (exp_reschk) check("res_addr", res_addr_o, exp_res);
    end
  end

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 9:    return 16'h0;
      1, 2:    return 16'h20 + 16'(4 * $urandom_range(0, 3));
      3, 4:    return 16'h40 + 16'(4 * $urandom_range(0, 3));
      5:       return 16'h60;
      6, 7:    return 16'h80 + 16'(4 * $urandom_range(0, 63));
      default: case ($urandom_range(0, 5))
                 0: return 16'h04;
                 1: return 16'h30;
                 2: return 16'h50;
                 3: return 16'h64;
                 4: return 16'h180;
                 default: return 16'h22;
               endcase
    endcase
  endfunction

  initial begin
    psel_i = 0; penable_i = 0; pwrite_i = 0; pstrb_i = 0; paddr_i = 0; pwdata_i = 0;
    done_i = 0; flags_i = 0;
    exp_pready = 0; exp_err = 0; exp_rdchk = 0; exp_reschk = 0; exp_rd = 0; exp_res = 0;
    for (int i = 0; i < 64; i++) res_mem[i] = $urandom;
    res_mem[2] = 32'hDEADBEEF;
    model_reset();

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_pready", pready_o, 1'b0);
    check("rst_prdata", prdata_o, 32'h0);
    check("rst_res_addr", res_addr_o, 16'h0);
    rst_ni = 1'b1;
    cmp_en = 1'b1;

    // Reset readback of CONTROL.
    apb(0, 16'h00, 32'h0, 4'h0, 0, 16'h0);
    check("lit_ctrl_reset", prdata_o, 32'h0);
    check("lit_first_ready", pready_o, 1'b1);

    // Byte-strobed operand write.
    apb(1, 16'h20, 32'h04030201, 4'hF, 0, 16'h0);
    apb(1, 16'h20, 32'hFF000000, 4'h8, 0, 16'h0);
    apb(0, 16'h20, 32'h0, 4'h0, 0, 16'h0);
    check("lit_opa_merge", prdata_o, 32'hFF030201);
    check("lit_a_row0", a_rows_o[31:0], 32'hFF030201);

    // Launch: start pulse for exactly one cycle, dims latched.
    apb(1, 16'h00, 32'h00000155, 4'hF, 0, 16'h0);
    idle(0, 16'h0);
    check("lit_start_hi", start_o, 1'b1);
    check("lit_dims", {dim_n_o, dim_k_o, dim_m_o, sp_slot_o}, 8'b01_01_01_01);
    idle(0, 16'h0);
    check("lit_start_lo", start_o, 1'b0);
    apb(0, 16'h00, 32'h0, 4'h0, 0, 16'h0);
    check("lit_ctrl_busy", prdata_o, 32'h00008154);

    // Operand write while busy is dropped.
    apb(1, 16'h40, 32'h12345678, 4'hF, 0, 16'h0);
    check("lit_busy_err", pslverr_o, ERR_EN);
    apb(0, 16'h40, 32'h0, 4'h0, 0, 16'h0);
    check("lit_opb_kept", prdata_o, 32'h0);

    // Completion loads FLAGS and clears busy; a FLAGS write clears it.
    idle(1, 16'h0005);
    apb(0, 16'h60, 32'h0, 4'h0, 0, 16'h0);
    check("lit_flags", prdata_o, 32'h5);
    apb(0, 16'h00, 32'h0, 4'h0, 0, 16'h0);
    check("lit_ctrl_idle", prdata_o, 32'h00000154);
    apb(1, 16'h60, 32'hFFFFFFFF, 4'hF, 0, 16'h0);
    apb(0, 16'h60, 32'h0, 4'h0, 0, 16'h0);
    check("lit_flags_clr", prdata_o, 32'h0);

    // Zero strobes leave the register alone.
    apb(1, 16'h24, 32'hFFFFFFFF, 4'h0, 0, 16'h0);
    apb(0, 16'h24, 32'h0, 4'h0, 0, 16'h0);
    check("lit_strb0", prdata_o, 32'h0);

    // START coinciding with done re-arms; new flags beat a FLAGS clear.
    apb(1, 16'h00, 32'h1, 4'hF, 0, 16'h0);
    apb(1, 16'h00, 32'h1, 4'hF, 1, 16'h00A0);
    apb(0, 16'h00, 32'h0, 4'h0, 0, 16'h0);
    check("lit_rearm", prdata_o, 32'h00008000);
    apb(1, 16'h60, 32'h0, 4'hF, 1, 16'h0033);
    apb(0, 16'h60, 32'h0, 4'h0, 0, 16'h0);
    check("lit_flags_win", prdata_o, 32'h33);

    // Result window read with one wait state.
    apb(0, 16'h88, 32'h0, 4'h0, 0, 16'h0);
    check("lit_result", prdata_o, 32'hDEADBEEF);

    // Randomized traffic with sporadic completions.
    for (int t = 0; t < 400; t++) begin
      apb($urandom_range(0, 1), rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 7) == 0,
          16'($urandom));
      repeat ($urandom_range(0, 2)) idle($urandom_range(0, 3) == 0, 16'($urandom));
    end

    // Reset landing in the result wait state.
    apb(1, 16'h20, 32'hA5A5A5A5, 4'hF, 0, 16'h0);
    apb(1, 16'h00, 32'h000003FD, 4'hF, 0, 16'h0);
    step(1, 0, 0, 16'h88, 32'h0, 4'h0, 0, 16'h0, 0, 0, 0, 32'h0, 0, 16'h0, 0);
    step(1, 1, 0, 16'h88, 32'h0, 4'h0, 0, 16'h0, 0, 0, 0, 32'h0, 1, 16'h2, 0);
    @(posedge clk_i); #1;
    cmp_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("arst_prdata", prdata_o, 32'h0);
    check("arst_pready", pready_o, 1'b0);
    check("arst_pslverr", pslverr_o, 1'b0);
    check("arst_start", start_o, 1'b0);
    check("arst_res_addr", res_addr_o, 16'h0);
    check("arst_a_rows", a_rows_o, 128'h0);
    check("arst_dims", {dim_n_o, dim_k_o, dim_m_o, sp_slot_o}, 8'h0);
    psel_i = 0; penable_i = 0;
    exp_pready = 0; exp_err = 0; exp_rdchk = 0; exp_reschk = 0;
    model_reset();
    @(negedge clk_i); #1;
    rst_ni = 1'b1;
    cmp_en = 1'b1;
    apb(0, 16'h00, 32'h0, 4'h0, 0, 16'h0);
    check("lit_post_rst_ctrl", prdata_o, 32'h0);
    apb(0, 16'h20, 32'h0, 4'h0, 0, 16'h0);
    check("lit_post_rst_opa", prdata_o, 32'h0);
    idle(0, 16'h0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
